// File: rtl/shares_stream_serializer.sv
// Streams one packed d-share sharing out as count/chunk narrow beats in shbus layout.
// Shares are only rewired, never combined, so the block adds no leakage of its own.
module shares_stream_serializer #(
  parameter int unsigned d         = 2,
  parameter int unsigned count     = 128,
  parameter int unsigned chunk     = 32,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [d*count-1:0]   in_shares,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [d*chunk-1:0]   out_shbus,
  output logic                 out_last,
  input  logic                 abort
);

  localparam int unsigned NB = (chunk == 0) ? 1 : count / chunk;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DW = d * count;

  if (chunk == 0 || (count % chunk) != 0) begin : g_bad_chunk
    $error("shares_stream_serializer: count must be a non-zero multiple of chunk");
  end
  if (d < 2) begin : g_bad_d
    $error("shares_stream_serializer: d must be at least 2");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_c;
  logic            in_xfer_c;
  logic            out_xfer_c;
  logic [CW-1:0]   beat_k_c;

  // State register; abort never clears the data, only the full flag and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state and handshake; abort wins over any same-cycle transfer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_c     = (state_q == BUSY) && (cnt_q == CW'(NB - 1));
    in_ready   = !abort && ((state_q == EMPTY) || (out_ready && last_c));
    in_xfer_c  = in_valid && in_ready;
    out_xfer_c = (state_q == BUSY) && out_ready && !abort;

    if (abort) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_c) begin
            data_d  = in_shares;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (out_xfer_c) begin
            if (!last_c) begin
              cnt_d = cnt_q + CW'(1);
            end else if (in_xfer_c) begin
              data_d = in_shares;
              cnt_d  = '0;
            end else begin
              cnt_d   = '0;
              state_d = EMPTY;
            end
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign out_valid = (state_q == BUSY);
  assign out_last  = last_c;

  // Pure wire remap of the selected beat: share j, beat-bit b lands at d*b+j.
  always_comb begin
    beat_k_c  = MSB_FIRST ? (CW'(NB - 1) - cnt_q) : cnt_q;
    out_shbus = '0;
    for (int unsigned b = 0; b < chunk; b++) begin
      for (int unsigned j = 0; j < d; j++) begin
        out_shbus[d*b + j] = data_q[count*j + 32'(beat_k_c)*chunk + b];
      end
    end
  end

endmodule

// File: tb/tb_shares_stream_serializer.sv
// Bench for shares_stream_serializer: LSB-first and MSB-first instances share one stimulus
// stream; a queue of expected beats is filled on input transfers and drained by a monitor.
module tb_shares_stream_serializer;

  localparam int unsigned D     = 2;
  localparam int unsigned COUNT = 8;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NB    = COUNT / CHUNK;
  localparam int unsigned DW    = D * COUNT;
  localparam int unsigned BW    = D * CHUNK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] in_shares = '0;

  logic          in_ready_a, in_ready_b;
  logic          out_valid_a, out_valid_b;
  logic          out_last_a, out_last_b;
  logic [BW-1:0] shbus_a, shbus_b;

  typedef struct {
    logic [BW-1:0] lsb_beat;
    logic [BW-1:0] msb_beat;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    m_accept = 1'b0;

  always #5 clk = ~clk;

  shares_stream_serializer #(.d(D), .count(COUNT), .chunk(CHUNK), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_shares(in_shares),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_shbus(shbus_a), .out_last(out_last_a),
    .abort(abort)
  );

  shares_stream_serializer #(.d(D), .count(COUNT), .chunk(CHUNK), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_shares(in_shares),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_shbus(shbus_b), .out_last(out_last_b),
    .abort(abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat k of a sharing: bit (D*b + j) = bit (k*CHUNK + b) of share j.
  function automatic logic [BW-1:0] beat_of(input logic [DW-1:0] s, input int unsigned k);
    int unsigned sv, sh, r;
    sv = 32'(s);
    r  = 0;
    for (int unsigned j = 0; j < D; j++) begin
      sh = (sv >> (COUNT * j)) & ((32'd1 << COUNT) - 32'd1);
      for (int unsigned b = 0; b < CHUNK; b++)
        r = r | (((sh >> (k * CHUNK + b)) & 32'd1) << (D * b + j));
    end
    return BW'(r);
  endfunction

  function automatic void push_sharing(input logic [DW-1:0] s);
    beat_t e;
    for (int unsigned k = 0; k < NB; k++) begin
      e.lsb_beat = beat_of(s, k);
      e.msb_beat = beat_of(s, NB - 1 - k);
      e.last     = (k == NB - 1);
      sb.push_back(e);
    end
  endfunction

  // Input side of the model: accept decision was made at the preceding falling edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (abort) sb.delete();
      else if (in_valid && m_accept) push_sharing(in_shares);
    end
  end

  // Monitor: compare presented outputs with the queue head and retire beats on transfer.
  always @(negedge clk) begin
    bit ev, hl;
    if (rst_n) begin
      ev = (sb.size() != 0);
      hl = ev ? sb[0].last : 1'b0;
      m_accept = !abort && (!ev || (out_ready && hl));
      chk("out_valid_lsb", 32'(out_valid_a), 32'(ev));
      chk("out_valid_msb", 32'(out_valid_b), 32'(ev));
      chk("in_ready_lsb", 32'(in_ready_a), 32'(m_accept));
      chk("in_ready_msb", 32'(in_ready_b), 32'(m_accept));
      if (ev) begin
        chk("shbus_lsb", 32'(shbus_a), 32'(sb[0].lsb_beat));
        chk("shbus_msb", 32'(shbus_b), 32'(sb[0].msb_beat));
        chk("last_lsb", 32'(out_last_a), 32'(hl));
        chk("last_msb", 32'(out_last_b), 32'(hl));
        if (out_ready && !abort) void'(sb.pop_front());
      end else begin
        chk("last_idle_lsb", 32'(out_last_a), 32'd0);
        chk("last_idle_msb", 32'(out_last_b), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid_a | out_valid_b), 32'd0);
    chk({tag, "_in_ready"}, 32'({in_ready_a, in_ready_b}), 32'h3);
    chk({tag, "_shbus_lsb"}, 32'(shbus_a), 32'd0);
    chk({tag, "_shbus_msb"}, 32'(shbus_b), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last_a | out_last_b), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single sharing with free-flowing output.
    in_shares = 16'h3CA5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(20);

    // Backpressure on beat 0 for five cycles.
    in_shares = DW'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    drain(20);

    // Back-to-back sharings with in_valid held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_shares = DW'($urandom);
      tick();
    end
    drain(20);

    // Abort during beat 0 with a new sharing offered in the same cycle.
    in_shares = DW'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b1;
    in_shares = DW'($urandom);
    tick();
    abort = 1'b0;
    tick();
    in_valid = 1'b0;
    drain(20);

    // Randomised traffic including sporadic aborts.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 15) == 0);
      in_shares = DW'($urandom);
      tick();
    end
    drain(40);

    // Asynchronous reset in the middle of a held sharing.
    in_shares = DW'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    in_shares = DW'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(20);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
